id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register of the 5-stage MIPS core.
- Sits directly downstream of control_unit and the register file.
- Latches the D-stage control word (RegWriteD, MemtoRegD, MemWriteD, ALUControlD, ALUSrcD, RegDstD), operands, register numbers and sign-extended immediate into E-stage copies.
- Supports hazard-unit stall (hold) and flush (bubble insertion).

Parameters:
DATA_W, 32, operand/immediate width
REG_W, 5, register-number width
ALUC_W, 3, ALU control width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
StallE  input  1  hold all E-stage contents this cycle
FlushE  input  1  load a bubble this cycle
ValidD  input  1  D-stage holds a real instruction
RegWriteD  input  1  control from control_unit
MemtoRegD  input  1  control from control_unit
MemWriteD  input  1  control from control_unit
ALUControlD  input  ALUC_W  control from control_unit
ALUSrcD  input  1  control from control_unit
RegDstD  input  1  control from control_unit
RD1D  input  DATA_W  register-file port 1 data
RD2D  input  DATA_W  register-file port 2 data
RsD  input  REG_W  instr[25:21]
RtD  input  REG_W  instr[20:16]
RdD  input  REG_W  instr[15:11]
SignImmD  input  DATA_W  sign-extended immediate
ValidE  output  1  E-stage holds a real instruction
RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  output  1 each  registered controls
ALUControlE  output  ALUC_W  registered ALU control
RD1E, RD2E, SignImmE  output  DATA_W  registered data
RsE, RtE, RdE  output  REG_W  registered register numbers

Behaviour:
- Clock and reset: single clock; reset is asynchronous, active-high, named reset; clock named clk.
- Reset: every output goes to 0 immediately on reset assertion, regardless of clk, and holds 0 while reset is high. First capture occurs on the first rising edge after deassertion.
- Latency: exactly 1 cycle, D input to E output.
- Per-edge priority: reset > FlushE > StallE > capture.
  - FlushE=1: all outputs load 0, including ValidE=0 and data fields. A zeroed control word is a NOP: no register write, no memory write.
  - FlushE=0, StallE=1: all outputs hold their current values.
  - Both 0: all outputs load their D counterparts. ValidE loads ValidD.
- FlushE and StallE together: flush wins and a bubble is loaded.
- Control gating: if ValidD=0 on a capture edge, RegWriteE and MemWriteE load 0. Data fields still load. No architectural side effects come from invalid slots.
- Reset mid-stall or mid-flush: async clear wins; stall/flush state is not remembered after reset.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- When defined: extra output port BubbleCntE [15:0].
  - Reset value 0.
  - Increments by 1 on each rising edge where FlushE=1, or where a capture occurs with ValidD=0.
  - Does not increment on stall edges.
  - Saturates at 16'hFFFF, no wrap.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: drive all D inputs nonzero, pulse reset between clock edges → all outputs 0 within the same timestep, before the next clk edge.
- Capture (R-type, Funct 100101): RegWriteD=1, RegDstD=1, ALUControlD=3'b001, RD1D=32'h0000_00F0, RD2D=32'h0000_000F, RsD=1, RtD=2, RdD=3, ValidD=1 → one edge later the E outputs match exactly, ValidE=1.
- Stall: after loading an LW word (MemtoRegD=1, ALUSrcD=1, SignImmD=32'hFFFF_FFFC), raise StallE for 3 cycles while the D inputs change to an SW word → E keeps the LW values for all 3 cycles, then loads the SW word (MemWriteE=1, RegWriteE=0) on the first edge after StallE drops.
- Flush vs stall: FlushE=1 and StallE=1 on the same edge with valid ADDI inputs → all E outputs 0, ValidE=0.
- Invalid gating: ValidD=0 with RegWriteD=1, MemWriteD=1, RD1D=32'h1234_5678 → RegWriteE=0, MemWriteE=0, RD1E=32'h1234_5678, ValidE=0.
- ID_EX_BUBBLE_CNT_EN: 5 flush edges, then 2 stall edges, then 1 invalid capture → BubbleCntE=6. Preload to 16'hFFFF, then flush → stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with stall, flush and valid gating (optional bubble counter: ID_EX_BUBBLE_CNT_EN)
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic              ALUSrcD,
    input  logic              RegDstD,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [REG_W-1:0]  RsD,
    input  logic [REG_W-1:0]  RtD,
    input  logic [REG_W-1:0]  RdD,
    input  logic [DATA_W-1:0] SignImmD,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              ALUSrcE,
    output logic              RegDstE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [REG_W-1:0]  RsE,
    output logic [REG_W-1:0]  RtE,
    output logic [REG_W-1:0]  RdE,
    output logic [DATA_W-1:0] SignImmE
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [15:0]       BubbleCntE
`endif
);

    // E-stage register: flush loads an all-zero NOP, stall holds, otherwise capture.
    // Invalid slots still carry data but never write the register file or memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            RsE         <= '0;
            RtE         <= '0;
            RdE         <= '0;
            SignImmE    <= '0;
        end else if (FlushE) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
            RegDstE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            RsE         <= '0;
            RtE         <= '0;
            RdE         <= '0;
            SignImmE    <= '0;
        end else if (!StallE) begin
            ValidE      <= ValidD;
            RegWriteE   <= RegWriteD & ValidD;
            MemtoRegE   <= MemtoRegD;
            MemWriteE   <= MemWriteD & ValidD;
            ALUControlE <= ALUControlD;
            ALUSrcE     <= ALUSrcD;
            RegDstE     <= RegDstD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            RsE         <= RsD;
            RtE         <= RtD;
            RdE         <= RdD;
            SignImmE    <= SignImmD;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic bubble_edge;
    assign bubble_edge = FlushE | (~StallE & ~ValidD);

    // Count bubbles entering E (flushes and invalid captures), saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BubbleCntE <= 16'h0000;
        end else if (bubble_edge && (BubbleCntE != 16'hFFFF)) begin
            BubbleCntE <= BubbleCntE + 16'h0001;
        end
    end
`else
    // No bubble accounting in this build.
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - scoreboard testbench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int ALUC_W = 3;
`ifdef ID_EX_BUBBLE_CNT_EN
    localparam int VW = 136;
`else
    localparam int VW = 120;
`endif

    typedef struct {
        string        name;
        logic [VW-1:0] vec;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              StallE, FlushE, ValidD;
    logic              RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [ALUC_W-1:0] ALUControlD;
    logic [DATA_W-1:0] RD1D, RD2D, SignImmD;
    logic [REG_W-1:0]  RsD, RtD, RdD;
    logic              ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [ALUC_W-1:0] ALUControlE;
    logic [DATA_W-1:0] RD1E, RD2E, SignImmE;
    logic [REG_W-1:0]  RsE, RtE, RdE;
    logic [15:0]       cnt_act;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .ALUC_W(ALUC_W)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
        .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
        .RD1E(RD1E), .RD2E(RD2E), .RsE(RsE), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .BubbleCntE(cnt_act)
`endif
    );

`ifndef ID_EX_BUBBLE_CNT_EN
    assign cnt_act = 16'h0000;
`endif

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] mk(
        input logic v, input logic rw, input logic mt, input logic mw,
        input logic [ALUC_W-1:0] ac, input logic src, input logic dst,
        input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
        input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd,
        input logic [DATA_W-1:0] imm, input logic [15:0] cnt);
`ifdef ID_EX_BUBBLE_CNT_EN
        return {v, rw, mt, mw, ac, src, dst, r1, r2, rs, rt, rd, imm, cnt};
`else
        return {v, rw, mt, mw, ac, src, dst, r1, r2, rs, rt, rd, imm};
`endif
    endfunction

    function automatic logic [VW-1:0] actual();
        return mk(ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE, RegDstE,
                  RD1E, RD2E, RsE, RtE, RdE, SignImmE, cnt_act);
    endfunction

    task automatic compare(input string nm, input logic [VW-1:0] e);
        logic [VW-1:0] a;
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Monitor: compare the E-stage outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            compare(e.name, e.vec);
        end
    end

    task automatic cyc(input string nm, input logic [VW-1:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        x.name = nm;
        x.vec  = e;
        q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mt, input logic mw,
                         input logic [ALUC_W-1:0] ac, input logic src, input logic dst,
                         input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
                         input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                         input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] imm);
        ValidD = v; RegWriteD = rw; MemtoRegD = mt; MemWriteD = mw; ALUControlD = ac;
        ALUSrcD = src; RegDstD = dst; RD1D = r1; RD2D = r2; RsD = rs; RtD = rt; RdD = rd;
        SignImmD = imm;
    endtask

    localparam logic [VW-1:0] ZERO = '0;
    logic [VW-1:0] lw_e, sw_e;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        drive(1, 1, 1, 1, 3'b111, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 5'h1F, 5'h1F, 32'hFFFF_FFFF);
        cyc("reset_init", ZERO);
        reset = 1'b0;

        // R-type OR: rs=1 rt=2 rd=3 funct 100101
        drive(1, 1, 0, 0, 3'b001, 0, 1, 32'h0000_00F0, 32'h0000_000F, 5'd1, 5'd2, 5'd3, 32'h0000_1825);
        cyc("rtype", mk(1, 1, 0, 0, 3'b001, 0, 1, 32'hF0, 32'hF, 5'd1, 5'd2, 5'd3, 32'h0000_1825, 16'd0));

        // Async reset between edges, D inputs still nonzero
        drive(1, 1, 1, 1, 3'b101, 1, 1, 32'hAAAA_AAAA, 32'h5555_5555, 5'd9, 5'd9, 5'd9, 32'h0000_1111);
        #1;
        reset = 1'b1;
        #1;
        compare("reset_async", ZERO);
        cyc("reset_hold", ZERO);
        reset = 1'b0;

        // LW: rs=4 rt=5, imm -4
        drive(1, 1, 1, 0, 3'b010, 1, 0, 32'h0000_0100, 32'h0000_0055, 5'd4, 5'd5, 5'h1F, 32'hFFFF_FFFC);
        lw_e = mk(1, 1, 1, 0, 3'b010, 1, 0, 32'h100, 32'h55, 5'd4, 5'd5, 5'h1F, 32'hFFFF_FFFC, 16'd0);
        cyc("lw", lw_e);

        // Stall three edges while D presents an SW
        StallE = 1'b1;
        drive(1, 0, 0, 1, 3'b010, 1, 0, 32'h0000_0200, 32'hDEAD_BEEF, 5'd6, 5'd7, 5'd0, 32'h0000_0008);
        sw_e = mk(1, 0, 0, 1, 3'b010, 1, 0, 32'h200, 32'hDEAD_BEEF, 5'd6, 5'd7, 5'd0, 32'h8, 16'd0);
        for (int i = 0; i < 3; i++) cyc("stall_hold", lw_e);
        StallE = 1'b0;
        cyc("sw_after_stall", sw_e);

        // Flush and stall together with a valid ADDI
        FlushE = 1'b1; StallE = 1'b1;
        drive(1, 1, 0, 0, 3'b010, 1, 0, 32'h0000_0010, 32'h0000_0000, 5'd8, 5'd9, 5'd0, 32'h0000_0005);
        cyc("flush_vs_stall", mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 16'd1));
        FlushE = 1'b0; StallE = 1'b0;

        // Invalid slot: write enables gated, data still loads
        drive(0, 1, 1, 1, 3'b110, 0, 1, 32'h1234_5678, 32'h0000_00A5, 5'd10, 5'd11, 5'd12, 32'h0000_6000);
        cyc("invalid_gate", mk(0, 0, 1, 0, 3'b110, 0, 1, 32'h1234_5678, 32'hA5, 5'd10, 5'd11, 5'd12, 32'h6000, 16'd2));

        // Recovery: back-to-back valid captures
        drive(1, 1, 0, 0, 3'b110, 0, 1, 32'h0000_0009, 32'h0000_0004, 5'd13, 5'd14, 5'd15, 32'h0000_7822);
        cyc("sub", mk(1, 1, 0, 0, 3'b110, 0, 1, 32'h9, 32'h4, 5'd13, 5'd14, 5'd15, 32'h7822, 16'd2));
        drive(1, 0, 0, 1, 3'b010, 1, 0, 32'h0000_0300, 32'h0000_0077, 5'd16, 5'd17, 5'd0, 32'h0000_0010);
        cyc("sw2", mk(1, 0, 0, 1, 3'b010, 1, 0, 32'h300, 32'h77, 5'd16, 5'd17, 5'd0, 32'h10, 16'd2));

`ifdef ID_EX_BUBBLE_CNT_EN
        // Bubble counter: 5 flushes, 2 stalls, 1 invalid capture -> 6
        reset = 1'b1;
        cyc("cnt_reset", ZERO);
        reset = 1'b0;
        FlushE = 1'b1;
        for (int i = 1; i <= 5; i++) cyc("cnt_flush", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'(i)));
        FlushE = 1'b0; StallE = 1'b1;
        for (int i = 0; i < 2; i++) cyc("cnt_stall", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd5));
        StallE = 1'b0;
        drive(0, 1, 0, 1, 3'b000, 0, 0, 32'h0000_0001, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0);
        cyc("cnt_invalid", mk(0, 0, 0, 0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 0, 16'd6));
        // Preload to saturation via flushes, then flush once more
        FlushE = 1'b1;
        repeat (65528) @(posedge clk);
        cyc("cnt_at_max", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF));
        cyc("cnt_saturate", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF));
        FlushE = 1'b0;
`endif

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
